// File: rtl/axi_lite_split_pkg.sv
// Shared types for the two-slave AXI4-Lite splitter: response codes, engine
// state encodings and channel payloads.
package axi_lite_split_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned RESP_W = 2;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_WAITB, W_RESP} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAITR, R_RESP} rd_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } axi_w_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [RESP_W-1:0] resp;
    } axi_r_t;

endpackage

// File: rtl/axi_lite_split_dec.sv
// Two-entry base/mask address decoder; slave 0 takes priority when both match.
module axi_lite_split_dec #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] M0_BASE    = '0,
    parameter logic [ADDR_WIDTH-1:0] M0_MASK    = '0,
    parameter logic [ADDR_WIDTH-1:0] M1_BASE    = '0,
    parameter logic [ADDR_WIDTH-1:0] M1_MASK    = '0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit_c,
    output logic                  sel_c
);

    logic hit0;
    logic hit1;

    assign hit0  = (addr & M0_MASK) == M0_BASE;
    assign hit1  = (addr & M1_MASK) == M1_BASE;
    assign hit_c = hit0 | hit1;
    assign sel_c = ~hit0 & hit1;

endmodule

// File: rtl/axi_lite_split2.sv
// AXI4-Lite 1-to-2 splitter with independent single-outstanding write and
// read engines; unmapped addresses complete locally with DECERR.
module axi_lite_split2
    import axi_lite_split_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] M0_BASE    = ADDR_WIDTH'(32'h7C40_0000),
    parameter logic [ADDR_WIDTH-1:0] M0_MASK    = ADDR_WIDTH'(32'hFFFF_0000),
    parameter logic [ADDR_WIDTH-1:0] M1_BASE    = ADDR_WIDTH'(32'h4160_0000),
    parameter logic [ADDR_WIDTH-1:0] M1_MASK    = ADDR_WIDTH'(32'hFFFF_0000)
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [PROT_W-1:0]     s_axi_awprot,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [STRB_W-1:0]     s_axi_wstrb,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [RESP_W-1:0]     s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [PROT_W-1:0]     s_axi_arprot,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [RESP_W-1:0]     s_axi_rresp,
    output logic                  m0_axi_awvalid,
    input  logic                  m0_axi_awready,
    output logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
    output logic [PROT_W-1:0]     m0_axi_awprot,
    output logic                  m0_axi_wvalid,
    input  logic                  m0_axi_wready,
    output logic [DATA_W-1:0]     m0_axi_wdata,
    output logic [STRB_W-1:0]     m0_axi_wstrb,
    input  logic                  m0_axi_bvalid,
    output logic                  m0_axi_bready,
    input  logic [RESP_W-1:0]     m0_axi_bresp,
    output logic                  m0_axi_arvalid,
    input  logic                  m0_axi_arready,
    output logic [ADDR_WIDTH-1:0] m0_axi_araddr,
    output logic [PROT_W-1:0]     m0_axi_arprot,
    input  logic                  m0_axi_rvalid,
    output logic                  m0_axi_rready,
    input  logic [DATA_W-1:0]     m0_axi_rdata,
    input  logic [RESP_W-1:0]     m0_axi_rresp,
    output logic                  m1_axi_awvalid,
    input  logic                  m1_axi_awready,
    output logic [ADDR_WIDTH-1:0] m1_axi_awaddr,
    output logic [PROT_W-1:0]     m1_axi_awprot,
    output logic                  m1_axi_wvalid,
    input  logic                  m1_axi_wready,
    output logic [DATA_W-1:0]     m1_axi_wdata,
    output logic [STRB_W-1:0]     m1_axi_wstrb,
    input  logic                  m1_axi_bvalid,
    output logic                  m1_axi_bready,
    input  logic [RESP_W-1:0]     m1_axi_bresp,
    output logic                  m1_axi_arvalid,
    input  logic                  m1_axi_arready,
    output logic [ADDR_WIDTH-1:0] m1_axi_araddr,
    output logic [PROT_W-1:0]     m1_axi_arprot,
    input  logic                  m1_axi_rvalid,
    output logic                  m1_axi_rready,
    input  logic [DATA_W-1:0]     m1_axi_rdata,
    input  logic [RESP_W-1:0]     m1_axi_rresp
);

    // Write engine state; per-port valid/ready vectors are one-hot on the selected slave.
    wr_state_e               w_state_q, w_state_n;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_n;
    logic [PROT_W-1:0]       aw_prot_q, aw_prot_n;
    axi_w_t                  w_pl_q, w_pl_n;
    logic                    aw_held_q, aw_held_n, w_held_q, w_held_n;
    logic                    w_sel_q, w_sel_n;
    logic                    awready_q, awready_n, wready_q, wready_n;
    logic [1:0]              m_awvalid_q, m_awvalid_n, m_wvalid_q, m_wvalid_n;
    logic [1:0]              m_bready_q, m_bready_n;
    logic                    bvalid_q, bvalid_n;
    logic [RESP_W-1:0]       bresp_q, bresp_n;

    // Read engine state.
    rd_state_e               r_state_q, r_state_n;
    logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_n;
    logic [PROT_W-1:0]       ar_prot_q, ar_prot_n;
    logic                    r_sel_q, r_sel_n;
    logic                    arready_q, arready_n;
    logic [1:0]              m_arvalid_q, m_arvalid_n, m_rready_q, m_rready_n;
    logic                    rvalid_q, rvalid_n;
    axi_r_t                  r_pl_q, r_pl_n;

    logic                    aw_fire, w_fire, ar_fire;
    logic [ADDR_WIDTH-1:0]   aw_dec_addr;
    logic                    aw_hit_c, aw_sel_c, ar_hit_c, ar_sel_c;

    assign aw_fire     = s_axi_awvalid & awready_q;
    assign w_fire      = s_axi_wvalid & wready_q;
    assign ar_fire     = s_axi_arvalid & arready_q;
    // Decode whichever address is current in the cycle AW and W become complete.
    assign aw_dec_addr = aw_fire ? s_axi_awaddr : aw_addr_q;

    axi_lite_split_dec #(
        .ADDR_WIDTH(ADDR_WIDTH), .M0_BASE(M0_BASE), .M0_MASK(M0_MASK),
        .M1_BASE(M1_BASE), .M1_MASK(M1_MASK)
    ) u_aw_dec (.addr(aw_dec_addr), .hit_c(aw_hit_c), .sel_c(aw_sel_c));

    axi_lite_split_dec #(
        .ADDR_WIDTH(ADDR_WIDTH), .M0_BASE(M0_BASE), .M0_MASK(M0_MASK),
        .M1_BASE(M1_BASE), .M1_MASK(M1_MASK)
    ) u_ar_dec (.addr(s_axi_araddr), .hit_c(ar_hit_c), .sel_c(ar_sel_c));

    // Write engine next-state and registered outputs.
    always_comb begin
        w_state_n   = w_state_q;
        aw_addr_n   = aw_addr_q;
        aw_prot_n   = aw_prot_q;
        w_pl_n      = w_pl_q;
        aw_held_n   = aw_held_q;
        w_held_n    = w_held_q;
        w_sel_n     = w_sel_q;
        awready_n   = awready_q;
        wready_n    = wready_q;
        m_awvalid_n = m_awvalid_q;
        m_wvalid_n  = m_wvalid_q;
        m_bready_n  = m_bready_q;
        bvalid_n    = bvalid_q;
        bresp_n     = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_addr_n = s_axi_awaddr;
                    aw_prot_n = s_axi_awprot;
                end
                if (w_fire) begin
                    w_pl_n = '{data: s_axi_wdata, strb: s_axi_wstrb};
                end
                aw_held_n = aw_held_q | aw_fire;
                w_held_n  = w_held_q | w_fire;
                awready_n = ~aw_held_n;
                wready_n  = ~w_held_n;
                if (aw_held_n && w_held_n) begin
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                    if (aw_hit_c) begin
                        w_state_n   = W_FWD;
                        w_sel_n     = aw_sel_c;
                        m_awvalid_n = aw_sel_c ? 2'b10 : 2'b01;
                        m_wvalid_n  = aw_sel_c ? 2'b10 : 2'b01;
                    end else begin
                        w_state_n = W_RESP;
                        bvalid_n  = 1'b1;
                        bresp_n   = RESP_DECERR;
                    end
                end
            end
            W_FWD: begin
                m_awvalid_n = m_awvalid_q & ~{m1_axi_awready, m0_axi_awready};
                m_wvalid_n  = m_wvalid_q & ~{m1_axi_wready, m0_axi_wready};
                if (m_awvalid_n == 2'b00 && m_wvalid_n == 2'b00) begin
                    w_state_n  = W_WAITB;
                    m_bready_n = w_sel_q ? 2'b10 : 2'b01;
                end
            end
            W_WAITB: begin
                if ((m_bready_q & {m1_axi_bvalid, m0_axi_bvalid}) != 2'b00) begin
                    w_state_n  = W_RESP;
                    m_bready_n = 2'b00;
                    bvalid_n   = 1'b1;
                    bresp_n    = w_sel_q ? m1_axi_bresp : m0_axi_bresp;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_n = W_IDLE;
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    // Read engine next-state and registered outputs.
    always_comb begin
        r_state_n   = r_state_q;
        ar_addr_n   = ar_addr_q;
        ar_prot_n   = ar_prot_q;
        r_sel_n     = r_sel_q;
        arready_n   = arready_q;
        m_arvalid_n = m_arvalid_q;
        m_rready_n  = m_rready_q;
        rvalid_n    = rvalid_q;
        r_pl_n      = r_pl_q;
        case (r_state_q)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ar_fire) begin
                    arready_n = 1'b0;
                    ar_addr_n = s_axi_araddr;
                    ar_prot_n = s_axi_arprot;
                    if (ar_hit_c) begin
                        r_state_n   = R_FWD;
                        r_sel_n     = ar_sel_c;
                        m_arvalid_n = ar_sel_c ? 2'b10 : 2'b01;
                    end else begin
                        r_state_n = R_RESP;
                        rvalid_n  = 1'b1;
                        r_pl_n    = '{data: '0, resp: RESP_DECERR};
                    end
                end
            end
            R_FWD: begin
                m_arvalid_n = m_arvalid_q & ~{m1_axi_arready, m0_axi_arready};
                if (m_arvalid_n == 2'b00) begin
                    r_state_n  = R_WAITR;
                    m_rready_n = r_sel_q ? 2'b10 : 2'b01;
                end
            end
            R_WAITR: begin
                if ((m_rready_q & {m1_axi_rvalid, m0_axi_rvalid}) != 2'b00) begin
                    r_state_n  = R_RESP;
                    m_rready_n = 2'b00;
                    rvalid_n   = 1'b1;
                    r_pl_n     = r_sel_q ? '{data: m1_axi_rdata, resp: m1_axi_rresp}
                                         : '{data: m0_axi_rdata, resp: m0_axi_rresp};
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    r_state_n = R_IDLE;
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_state_n_reset: begin end
            w_state_q   <= W_IDLE;
            aw_addr_q   <= '0;
            aw_prot_q   <= '0;
            w_pl_q      <= '0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            w_sel_q     <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            m_awvalid_q <= 2'b00;
            m_wvalid_q  <= 2'b00;
            m_bready_q  <= 2'b00;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            r_state_q   <= R_IDLE;
            ar_addr_q   <= '0;
            ar_prot_q   <= '0;
            r_sel_q     <= 1'b0;
            arready_q   <= 1'b0;
            m_arvalid_q <= 2'b00;
            m_rready_q  <= 2'b00;
            rvalid_q    <= 1'b0;
            r_pl_q      <= '0;
        end else begin
            w_state_q   <= w_state_n;
            aw_addr_q   <= aw_addr_n;
            aw_prot_q   <= aw_prot_n;
            w_pl_q      <= w_pl_n;
            aw_held_q   <= aw_held_n;
            w_held_q    <= w_held_n;
            w_sel_q     <= w_sel_n;
            awready_q   <= awready_n;
            wready_q    <= wready_n;
            m_awvalid_q <= m_awvalid_n;
            m_wvalid_q  <= m_wvalid_n;
            m_bready_q  <= m_bready_n;
            bvalid_q    <= bvalid_n;
            bresp_q     <= bresp_n;
            r_state_q   <= r_state_n;
            ar_addr_q   <= ar_addr_n;
            ar_prot_q   <= ar_prot_n;
            r_sel_q     <= r_sel_n;
            arready_q   <= arready_n;
            m_arvalid_q <= m_arvalid_n;
            m_rready_q  <= m_rready_n;
            rvalid_q    <= rvalid_n;
            r_pl_q      <= r_pl_n;
        end
    end

    assign s_axi_awready  = awready_q;
    assign s_axi_wready   = wready_q;
    assign s_axi_bvalid   = bvalid_q;
    assign s_axi_bresp    = bresp_q;
    assign s_axi_arready  = arready_q;
    assign s_axi_rvalid   = rvalid_q;
    assign s_axi_rdata    = r_pl_q.data;
    assign s_axi_rresp    = r_pl_q.resp;

    // Payload fans out to both slaves; only the selected one ever sees a valid.
    assign m0_axi_awvalid = m_awvalid_q[0];
    assign m0_axi_awaddr  = aw_addr_q;
    assign m0_axi_awprot  = aw_prot_q;
    assign m0_axi_wvalid  = m_wvalid_q[0];
    assign m0_axi_wdata   = w_pl_q.data;
    assign m0_axi_wstrb   = w_pl_q.strb;
    assign m0_axi_bready  = m_bready_q[0];
    assign m0_axi_arvalid = m_arvalid_q[0];
    assign m0_axi_araddr  = ar_addr_q;
    assign m0_axi_arprot  = ar_prot_q;
    assign m0_axi_rready  = m_rready_q[0];

    assign m1_axi_awvalid = m_awvalid_q[1];
    assign m1_axi_awaddr  = aw_addr_q;
    assign m1_axi_awprot  = aw_prot_q;
    assign m1_axi_wvalid  = m_wvalid_q[1];
    assign m1_axi_wdata   = w_pl_q.data;
    assign m1_axi_wstrb   = w_pl_q.strb;
    assign m1_axi_bready  = m_bready_q[1];
    assign m1_axi_arvalid = m_arvalid_q[1];
    assign m1_axi_araddr  = ar_addr_q;
    assign m1_axi_arprot  = ar_prot_q;
    assign m1_axi_rready  = m_rready_q[1];

endmodule

// File: tb/tb_axi_lite_split2.sv
// Directed self-checking bench for axi_lite_split2: routing, DECERR, stalls,
// backpressure and reset-in-flight.
module tb_axi_lite_split2;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;

    logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
    logic [2:0]  m0_awprot, m0_arprot;
    logic [3:0]  m0_wstrb;
    logic [1:0]  m0_bresp, m0_rresp;

    logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
    logic [2:0]  m1_awprot, m1_arprot;
    logic [3:0]  m1_wstrb;
    logic [1:0]  m1_bresp, m1_rresp;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 axi_aclk = ~axi_aclk;

    axi_lite_split2 dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready), .s_axi_awaddr(s_awaddr), .s_axi_awprot(s_awprot),
        .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready), .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb),
        .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready), .s_axi_bresp(s_bresp),
        .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready), .s_axi_araddr(s_araddr), .s_axi_arprot(s_arprot),
        .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
        .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready), .m0_axi_awaddr(m0_awaddr), .m0_axi_awprot(m0_awprot),
        .m0_axi_wvalid(m0_wvalid), .m0_axi_wready(m0_wready), .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb),
        .m0_axi_bvalid(m0_bvalid), .m0_axi_bready(m0_bready), .m0_axi_bresp(m0_bresp),
        .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready), .m0_axi_araddr(m0_araddr), .m0_axi_arprot(m0_arprot),
        .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready), .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp),
        .m1_axi_awvalid(m1_awvalid), .m1_axi_awready(m1_awready), .m1_axi_awaddr(m1_awaddr), .m1_axi_awprot(m1_awprot),
        .m1_axi_wvalid(m1_wvalid), .m1_axi_wready(m1_wready), .m1_axi_wdata(m1_wdata), .m1_axi_wstrb(m1_wstrb),
        .m1_axi_bvalid(m1_bvalid), .m1_axi_bready(m1_bready), .m1_axi_bresp(m1_bresp),
        .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready), .m1_axi_araddr(m1_araddr), .m1_axi_arprot(m1_arprot),
        .m1_axi_rvalid(m1_rvalid), .m1_axi_rready(m1_rready), .m1_axi_rdata(m1_rdata), .m1_axi_rresp(m1_rresp)
    );

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic test_reset();
        axi_aresetn = 1'b0;
        tick();
        tick();
        n_vec++; if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 5'b0) begin n_err++; $display("FAIL rst_s_hs got %b want 00000", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}); end
        n_vec++; if ({m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready, m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready} !== 10'b0) begin n_err++; $display("FAIL rst_m_hs got %b want 0", {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready, m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready}); end
        n_vec++; if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin n_err++; $display("FAIL rst_resp got %h want 0", {s_bresp, s_rresp, s_rdata}); end
        axi_aresetn = 1'b1;
        tick();
        n_vec++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin n_err++; $display("FAIL rst_release_rdy got %b want 111", {s_awready, s_wready, s_arready}); end
    endtask

    task automatic test_write_m0();
        s_awvalid = 1'b1; s_awaddr = 32'h7C40_0010; s_awprot = 3'b010;
        tick();
        s_awvalid = 1'b0;
        n_vec++; if ({s_awready, s_wready} !== 2'b01) begin n_err++; $display("FAIL wr0_aw_taken got %b want 01", {s_awready, s_wready}); end
        tick();
        tick();
        s_wvalid = 1'b1; s_wdata = 32'hA5A5_1234; s_wstrb = 4'hF;
        tick();
        s_wvalid = 1'b0;
        n_vec++; if ({m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid} !== 4'b1100) begin n_err++; $display("FAIL wr0_valids got %b want 1100", {m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid}); end
        n_vec++; if ({m0_awaddr, m0_awprot, m0_wdata, m0_wstrb} !== {32'h7C40_0010, 3'b010, 32'hA5A5_1234, 4'hF}) begin n_err++; $display("FAIL wr0_payload got %h %h %h %h", m0_awaddr, m0_awprot, m0_wdata, m0_wstrb); end
        m0_awready = 1'b1; m0_wready = 1'b1;
        tick();
        m0_awready = 1'b0; m0_wready = 1'b0;
        n_vec++; if ({m0_awvalid, m0_wvalid, m0_bready, m1_bready} !== 4'b0010) begin n_err++; $display("FAIL wr0_waitb got %b want 0010", {m0_awvalid, m0_wvalid, m0_bready, m1_bready}); end
        m0_bvalid = 1'b1; m0_bresp = 2'b00;
        tick();
        m0_bvalid = 1'b0;
        n_vec++; if ({s_bvalid, s_bresp, m0_bready} !== 4'b1000) begin n_err++; $display("FAIL wr0_bresp got %b want 1000", {s_bvalid, s_bresp, m0_bready}); end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        n_vec++; if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin n_err++; $display("FAIL wr0_done got %b want 011", {s_bvalid, s_awready, s_wready}); end
    endtask

    task automatic test_w_first_m1();
        s_wvalid = 1'b1; s_wdata = 32'hCAFE_F00D; s_wstrb = 4'b0101;
        tick();
        s_wvalid = 1'b0;
        n_vec++; if ({s_awready, s_wready, m1_awvalid} !== 3'b100) begin n_err++; $display("FAIL wf_w_taken got %b want 100", {s_awready, s_wready, m1_awvalid}); end
        s_awvalid = 1'b1; s_awaddr = 32'h4160_0040; s_awprot = 3'b001;
        tick();
        s_awvalid = 1'b0;
        n_vec++; if ({m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid} !== 4'b0011) begin n_err++; $display("FAIL wf_valids got %b want 0011", {m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid}); end
        n_vec++; if ({m1_awaddr, m1_awprot, m1_wdata, m1_wstrb} !== {32'h4160_0040, 3'b001, 32'hCAFE_F00D, 4'b0101}) begin n_err++; $display("FAIL wf_payload got %h %h %h %h", m1_awaddr, m1_awprot, m1_wdata, m1_wstrb); end
        m1_awready = 1'b1;
        tick();
        m1_awready = 1'b0;
        n_vec++; if ({m1_awvalid, m1_wvalid, m1_bready} !== 3'b010) begin n_err++; $display("FAIL wf_split_accept got %b want 010", {m1_awvalid, m1_wvalid, m1_bready}); end
        m1_wready = 1'b1;
        tick();
        m1_wready = 1'b0;
        n_vec++; if ({m1_wvalid, m1_bready, m0_bready} !== 3'b010) begin n_err++; $display("FAIL wf_waitb got %b want 010", {m1_wvalid, m1_bready, m0_bready}); end
        m1_bvalid = 1'b1; m1_bresp = 2'b10;
        tick();
        m1_bvalid = 1'b0;
        n_vec++; if ({s_bvalid, s_bresp} !== 3'b110) begin n_err++; $display("FAIL wf_bresp got %b want 110", {s_bvalid, s_bresp}); end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
    endtask

    task automatic test_read_m1();
        s_arvalid = 1'b1; s_araddr = 32'h4160_0100; s_arprot = 3'b100;
        tick();
        s_arvalid = 1'b0;
        n_vec++; if ({m1_arvalid, m0_arvalid, s_arready} !== 3'b100) begin n_err++; $display("FAIL rd1_arvalid got %b want 100", {m1_arvalid, m0_arvalid, s_arready}); end
        n_vec++; if ({m1_araddr, m1_arprot} !== {32'h4160_0100, 3'b100}) begin n_err++; $display("FAIL rd1_araddr got %h %h", m1_araddr, m1_arprot); end
        m1_arready = 1'b1;
        tick();
        m1_arready = 1'b0;
        n_vec++; if ({m1_arvalid, m1_rready, m0_rready} !== 3'b010) begin n_err++; $display("FAIL rd1_waitr got %b want 010", {m1_arvalid, m1_rready, m0_rready}); end
        m1_rvalid = 1'b1; m1_rdata = 32'hDEAD_BEEF; m1_rresp = 2'b10;
        tick();
        m1_rvalid = 1'b0;
        n_vec++; if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, 32'hDEAD_BEEF, 2'b10}) begin n_err++; $display("FAIL rd1_resp got %b %h %b", s_rvalid, s_rdata, s_rresp); end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        n_vec++; if ({s_rvalid, s_arready} !== 2'b01) begin n_err++; $display("FAIL rd1_done got %b want 01", {s_rvalid, s_arready}); end
    endtask

    task automatic test_decerr();
        s_awvalid = 1'b1; s_awaddr = 32'h1234_0000; s_wvalid = 1'b1; s_wdata = 32'h5555_AAAA;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_vec++; if ({s_bvalid, s_bresp} !== 3'b111) begin n_err++; $display("FAIL de_wr_bresp got %b want 111", {s_bvalid, s_bresp}); end
        n_vec++; if ({m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid} !== 4'b0) begin n_err++; $display("FAIL de_wr_no_fwd got %b want 0000", {m0_awvalid, m0_wvalid, m1_awvalid, m1_wvalid}); end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        // Just past the top of slave 0's window.
        s_arvalid = 1'b1; s_araddr = 32'h7C41_0000;
        tick();
        s_arvalid = 1'b0;
        n_vec++; if ({s_rvalid, s_rdata, s_rresp, m0_arvalid, m1_arvalid} !== {1'b1, 32'h0, 2'b11, 2'b00}) begin n_err++; $display("FAIL de_rd got %b %h %b %b%b", s_rvalid, s_rdata, s_rresp, m0_arvalid, m1_arvalid); end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
    endtask

    task automatic test_concurrent_stall();
        s_awvalid = 1'b1; s_awaddr = 32'h7C40_FFFC; s_wvalid = 1'b1; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'b1000;
        s_arvalid = 1'b1; s_araddr = 32'h4160_0004;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if ({m0_awvalid, m0_wvalid, m1_arvalid, m0_arvalid, m1_awvalid, s_bvalid, s_rvalid} !== 7'b1110000) begin n_err++; $display("FAIL cc_stall%0d got %b want 1110000", i, {m0_awvalid, m0_wvalid, m1_arvalid, m0_arvalid, m1_awvalid, s_bvalid, s_rvalid}); end
            n_vec++; if ({m0_awaddr, m0_wdata, m1_araddr} !== {32'h7C40_FFFC, 32'h0BAD_F00D, 32'h4160_0004}) begin n_err++; $display("FAIL cc_hold%0d got %h %h %h", i, m0_awaddr, m0_wdata, m1_araddr); end
            tick();
        end
        m0_awready = 1'b1; m0_wready = 1'b1; m1_arready = 1'b1;
        tick();
        m0_awready = 1'b0; m0_wready = 1'b0; m1_arready = 1'b0;
        m0_bvalid = 1'b1; m0_bresp = 2'b00; m1_rvalid = 1'b1; m1_rdata = 32'h1111_2222; m1_rresp = 2'b00;
        tick();
        m0_bvalid = 1'b0; m1_rvalid = 1'b0;
        n_vec++; if ({s_bvalid, s_bresp, s_rvalid, s_rresp, s_rdata} !== {1'b1, 2'b00, 1'b1, 2'b00, 32'h1111_2222}) begin n_err++; $display("FAIL cc_resp got %b %b %b %b %h", s_bvalid, s_bresp, s_rvalid, s_rresp, s_rdata); end
        s_bready = 1'b1; s_rready = 1'b1;
        tick();
        s_bready = 1'b0; s_rready = 1'b0;
    endtask

    task automatic test_reset_in_waitb();
        s_awvalid = 1'b1; s_awaddr = 32'h7C40_0044; s_wvalid = 1'b1; s_wdata = 32'h7777_8888;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        m0_awready = 1'b1; m0_wready = 1'b1;
        tick();
        m0_awready = 1'b0; m0_wready = 1'b0;
        n_vec++; if (m0_bready !== 1'b1) begin n_err++; $display("FAIL rw_in_waitb got %b want 1", m0_bready); end
        #2 axi_aresetn = 1'b0;
        #1;
        n_vec++; if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, m0_bready, m0_awvalid, m0_wvalid} !== 8'b0) begin n_err++; $display("FAIL rw_async got %b want 0", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, m0_bready, m0_awvalid, m0_wvalid}); end
        tick();
        axi_aresetn = 1'b1;
        tick();
        n_vec++; if ({s_awready, s_bvalid, m0_bready} !== 3'b100) begin n_err++; $display("FAIL rw_release got %b want 100", {s_awready, s_bvalid, m0_bready}); end
        tick();
        tick();
        n_vec++; if ({s_bvalid, m0_bready, s_awready} !== 3'b001) begin n_err++; $display("FAIL rw_no_stray got %b want 001", {s_bvalid, m0_bready, s_awready}); end
    endtask

    task automatic test_bready_backpressure();
        s_awvalid = 1'b1; s_awaddr = 32'h1234_0000; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0; s_awaddr = 32'h7C40_0030; s_wdata = 32'h3030_3030; s_wstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            n_vec++; if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b11100) begin n_err++; $display("FAIL bp_hold%0d got %b want 11100", i, {s_bvalid, s_bresp, s_awready, s_wready}); end
            tick();
        end
        n_vec++; if (m0_awvalid !== 1'b0) begin n_err++; $display("FAIL bp_no_aw got %b want 0", m0_awvalid); end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        n_vec++; if ({s_bvalid, s_awready} !== 2'b01) begin n_err++; $display("FAIL bp_release got %b want 01", {s_bvalid, s_awready}); end
        s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        n_vec++; if ({m0_awvalid, m0_awaddr, m0_wdata} !== {1'b1, 32'h7C40_0030, 32'h3030_3030}) begin n_err++; $display("FAIL bp_next got %b %h %h", m0_awvalid, m0_awaddr, m0_wdata); end
        m0_awready = 1'b1; m0_wready = 1'b1;
        tick();
        m0_awready = 1'b0; m0_wready = 1'b0; m0_bvalid = 1'b1; m0_bresp = 2'b00;
        tick();
        m0_bvalid = 1'b0; s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        n_vec++; if ({s_bvalid, s_awready} !== 2'b01) begin n_err++; $display("FAIL bp_final got %b want 01", {s_bvalid, s_awready}); end
    endtask

    initial begin
        s_awvalid = 1'b0; s_awaddr = '0; s_awprot = '0;
        s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_bready = 1'b0;
        s_arvalid = 1'b0; s_araddr = '0; s_arprot = '0; s_rready = 1'b0;
        m0_awready = 1'b0; m0_wready = 1'b0; m0_bvalid = 1'b0; m0_bresp = '0;
        m0_arready = 1'b0; m0_rvalid = 1'b0; m0_rdata = '0; m0_rresp = '0;
        m1_awready = 1'b0; m1_wready = 1'b0; m1_bvalid = 1'b0; m1_bresp = '0;
        m1_arready = 1'b0; m1_rvalid = 1'b0; m1_rdata = '0; m1_rresp = '0;
        test_reset();
        test_write_m0();
        test_w_first_m1();
        test_read_m1();
        test_decerr();
        test_concurrent_stall();
        test_reset_in_waitb();
        test_bready_backpressure();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_split2.md
AXI_LITE_SPLIT2 -- requirements
Module: axi_lite_split2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter M0_BASE, default 32'h7C40_0000, slave 0 base.
REQ-003 SHALL have parameter M0_MASK, default 32'hFFFF_0000, slave 0 decode mask.
REQ-004 SHALL have parameter M1_BASE, default 32'h4160_0000, slave 1 base.
REQ-005 SHALL have parameter M1_MASK, default 32'hFFFF_0000, slave 1 decode mask.
REQ-006 SHALL have port axi_aclk, input, 1, sole clock.
REQ-007 SHALL have port axi_aresetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have s_axi AW channel (awvalid in 1, awready out 1, awaddr in ADDR_WIDTH, awprot in 3), upstream master.
REQ-009 SHALL have s_axi W channel (wvalid in 1, wready out 1, wdata in 32, wstrb in 4).
REQ-010 SHALL have s_axi B channel (bvalid out 1, bready in 1, bresp out 2).
REQ-011 SHALL have s_axi AR channel (arvalid in 1, arready out 1, araddr in ADDR_WIDTH, arprot in 3).
REQ-012 SHALL have s_axi R channel (rvalid out 1, rready in 1, rdata out 32, rresp out 2).
REQ-013 SHALL have m0_axi and m1_axi with the same five channels, directions mirrored, for downstream slaves.

Function
REQ-014 SHALL run independent write and read engines, each with at most one outstanding transaction.
REQ-015 Write FSM SHALL use states W_IDLE, W_FWD, W_WAITB, W_RESP.
REQ-016 W_IDLE: awready high until AW captured; wready high until W captured; either order or same cycle.
REQ-017 SHALL decode in the cycle both AW and W are held: hit0 = (addr & M0_MASK) == M0_BASE, else hit1 likewise; hit0 wins if both match.
REQ-018 On a hit, SHALL enter W_FWD the next cycle, driving registered awvalid/wvalid on the selected port only, unmodified addr/prot/data/strb.
REQ-019 W_FWD: each valid SHALL drop independently on its ready; SHALL enter W_WAITB once both are accepted.
REQ-020 W_WAITB: SHALL drive bready high on the selected port, capture bresp on bvalid, then enter W_RESP.
REQ-021 On a miss, SHALL go straight to W_RESP with bresp = 2'b11 (DECERR); no downstream access.
REQ-022 W_RESP: s_bvalid high with held bresp until s_bready; SHALL then return to W_IDLE.
REQ-023 Read FSM SHALL use R_IDLE, R_FWD, R_WAITR, R_RESP, with the same rules; a miss SHALL return rdata = 32'h0 and rresp = 2'b11.
REQ-024 Latency: both AW and W accepted at cycle N -> m awvalid at N+1; downstream b accepted at M -> s_bvalid at M+1; a miss gives s_bvalid at N+1.
REQ-025 Simultaneous read and write to the same slave SHALL proceed concurrently on separate channels, without ordering between them.
REQ-026 Unselected port valids and readies SHALL stay 0.
REQ-027 Valid SHALL never depend combinationally on ready on any port.

Reset
REQ-028 While axi_aresetn is low, all valids, readies and bready/rready SHALL be 0; bresp/rresp/rdata SHALL be 0; FSMs SHALL be IDLE.
REQ-029 A transaction in flight at reset SHALL be abandoned with no response.
REQ-030 First cycle after release: s_awready, s_wready and s_arready SHALL be 1.

Structure
REQ-031 Package axi_lite_split_pkg SHALL hold the response codes (OKAY, SLVERR, DECERR) and the write/read state encodings.
REQ-032 Sub-module axi_lite_split_dec SHALL implement the two-entry base/mask decoder, instantiated once for AW and once for AR.

Verification
REQ-033 Write to 0x7C40_0010, AW before W by 3 cycles -> m0 AW/W carry 0x7C40_0010, m1 idle, s_bresp 2'b00.
REQ-034 Read from 0x4160_0100, m1 returns 0xDEAD_BEEF with SLVERR -> s_rdata 0xDEAD_BEEF, s_rresp 2'b10.
REQ-035 Write to 0x1234_0000 -> no m valid, s_bvalid at N+1 with 2'b11.
REQ-036 Concurrent write to m0 and read from m1, downstream readies held low 5 cycles -> both complete, valids stable while stalled.
REQ-037 Reset asserted in W_WAITB -> all outputs 0 asynchronously; after release awready=1 and no stray bvalid.
REQ-038 s_bready held low 10 cycles in W_RESP -> bvalid/bresp stable; no new AW accepted until the handshake.
